sort4_seq: RTL
==============

# sort4_seq

Sequential 4-element sorter that time-multiplexes a single compare-and-swap unit over the five-step 4-input sorting network: (0,2), (1,3), (0,1), (2,3), (1,2). It sits beside the combinational sorters as the area-optimised alternative: one comparator instead of five, at the cost of multi-cycle latency. It exchanges data with upstream and downstream logic through valid/ready handshakes and owns the step scheduling of the shared comparator.

## Interface
- `T`, default 3: MSB index of each element; elements are `T+1` bits, unsigned.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  upstream offers a set of four elements.
- `in_ready`  out  1  block can accept a set.
- `a`, `b`, `c`, `d`  in  T+1 each  elements, loaded into slots 0..3.
- `out_valid`  out  1  sorted result available.
- `out_ready`  in  1  downstream accepts the result.
- `ra`, `rb`, `rc`, `rd`  out  T+1 each  sorted slots 0..3.
- `busy`  out  1  high in RUN or DONE.

## Operation
- Four slot registers `v0`..`v3`, a 3-bit step counter, and a 3-state FSM: IDLE, RUN, DONE.
- IDLE:
  - `in_ready=1`.
  - When `in_valid && in_ready`: load `v0..v3 = a,b,c,d`, set step to 0, go to RUN.
- RUN:
  - Each cycle, the comparator takes the slot pair selected by the step: 0:(0,2), 1:(1,3), 2:(0,1), 3:(2,3), 4:(1,2).
  - If the low-index slot is strictly greater than the high-index slot, the two are swapped; otherwise both are unchanged.
  - The step increments each cycle. At step 4, go to DONE after the update.
  - Inputs are ignored during RUN.
- DONE:
  - `out_valid=1`.
  - `ra..rd` drive `v0..v3` directly and stay stable while `out_valid && !out_ready`.
  - On `out_ready`, go to IDLE.
- Comparison is unsigned, full width. Equal elements are never swapped, so duplicates pass through without a swap.
- Step counter values 5–7 are unreachable. If one is seen, the FSM goes to IDLE.
- Reset asserted at any time:
  - State forced to IDLE, in-flight data discarded.
  - All slots and the step counter cleared.
  - Outputs `in_ready=1` after release, `out_valid=0`, `busy=0`, `ra..rd=0`.

## Timing
- Accept edge E0 loads the slots.
- Compare steps occur on edges E1..E5, and `out_valid` rises after E5. Latency is 5 cycles from accept to result.
- Minimum period between accepts is 7 cycles: accept, 5 RUN cycles, 1 DONE cycle with `out_ready=1`, then IDLE.
- `in_ready` is low in RUN and DONE. No accept can happen on the same edge as a result handoff; the next accept occurs at the earliest on the cycle after returning to IDLE.
- `in_ready`, `out_valid` and `busy` are pure functions of state and registered; none combinationally depends on `in_valid` or `out_ready`.
- `out_ready` held low keeps the block in DONE indefinitely with outputs frozen.

## Configuration
- `SORT4_SEQ_DESCEND_EN`:
  - When defined, the swap condition becomes low-index slot strictly less than high-index slot. Result: `ra >= rb >= rc >= rd`.
  - When undefined, results are ascending: `ra <= rb <= rc <= rd`.
- Latency, handshake and reset behaviour are identical in both builds.

## Structure
- Package `sort4_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the step-to-pair index constants as two 5-entry arrays of 2-bit slot indices;
  - constant `SORT4_STEPS = 5`.
- Sub-module `sort4_cmp_swap`: combinational, width parameter, inputs `x`, `y`, outputs `lo`, `hi`. The descend macro is applied inside it.
- The top level holds the FSM, the step counter, the slot mux feeding `sort4_cmp_swap`, and slot write-back.

## Test plan
- Reset, then `a,b,c,d = 9,3,7,1` with `in_valid=1` → `in_ready` drops next cycle; `out_valid` rises exactly 5 cycles after accept with `ra..rd = 1,3,7,9`; `busy=1` throughout.
- Input `15,15,0,15` → `0,15,15,15`. Check the trace shows no swap on equal pairs: slots unchanged on steps 1, 3 and 4.
- Hold `out_ready=0` for 10 cycles in DONE while driving new `a..d` with `in_valid=1` → outputs frozen at the prior result, `in_ready=0`. Raise `out_ready` → IDLE next cycle; the new set is accepted one cycle later.
- Assert `rst_n=0` during step 2 of sorting `4,3,2,1` → all outputs 0 immediately. After release, `in_ready=1`, and a subsequent `2,1,4,3` yields `1,2,3,4`.
- Back-to-back sets `8,6,4,2` then `1,1,1,0`, with `in_valid` held and `out_ready=1` → accept interval is exactly 7 cycles; results are `2,4,6,8` and `0,1,1,1`.
- With `SORT4_SEQ_DESCEND_EN` defined, `9,3,7,1` → `9,7,3,1`, with the same 5-cycle latency.

Source files
------------

// File: rtl/sort4_pkg.sv
// Shared types and constants for the sequential 4-element sorter.
// The compare-and-swap schedule is the 5-step 4-input sorting network.
package sort4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sort4_state_t;

  localparam int SORT4_STEPS = 5;

  // Slot pair compared at each step; the low-index slot always receives the "lo" result.
  localparam logic [1:0] SORT4_LO_IDX [SORT4_STEPS] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd1};
  localparam logic [1:0] SORT4_HI_IDX [SORT4_STEPS] = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd2};

  localparam logic [2:0] SORT4_LAST_STEP = 3'(SORT4_STEPS - 1);

endpackage

// File: rtl/sort4_cmp_swap.sv
// Combinational compare-and-swap shared by every step of the sorter.
// SORT4_SEQ_DESCEND_EN selects descending order; equal inputs never swap.
module sort4_cmp_swap #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  logic swap;

`ifdef SORT4_SEQ_DESCEND_EN
  assign swap = (x < y);
`else
  assign swap = (x > y);
`endif

  assign lo = swap ? y : x;
  assign hi = swap ? x : y;

endmodule

// File: rtl/sort4_seq.sv
// Sequential 4-element sorter: one shared compare-and-swap stepped over five cycles.
// Sort direction set by SORT4_SEQ_DESCEND_EN inside sort4_cmp_swap.
module sort4_seq
  import sort4_pkg::*;
#(
  parameter int T = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [T:0] a,
  input  logic [T:0] b,
  input  logic [T:0] c,
  input  logic [T:0] d,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [T:0] ra,
  output logic [T:0] rb,
  output logic [T:0] rc,
  output logic [T:0] rd,
  output logic       busy
);

  sort4_state_t state;
  logic [2:0]   step;
  logic [T:0]   v [4];

  logic [1:0]   lo_idx;
  logic [1:0]   hi_idx;
  logic [T:0]   cmp_x;
  logic [T:0]   cmp_y;
  logic [T:0]   cmp_lo;
  logic [T:0]   cmp_hi;

  // Out-of-range steps select slot 0 for both operands; the FSM drops to IDLE anyway.
  always_comb begin
    lo_idx = 2'd0;
    hi_idx = 2'd0;
    if (step <= SORT4_LAST_STEP) begin
      lo_idx = SORT4_LO_IDX[step];
      hi_idx = SORT4_HI_IDX[step];
    end
  end

  assign cmp_x = v[lo_idx];
  assign cmp_y = v[hi_idx];

  sort4_cmp_swap #(
    .DATA_W(T + 1)
  ) u_cmp (
    .x  (cmp_x),
    .y  (cmp_y),
    .lo (cmp_lo),
    .hi (cmp_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= 3'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < 4; i++) v[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            v[0]     <= a;
            v[1]     <= b;
            v[2]     <= c;
            v[3]     <= d;
            step     <= 3'd0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (step > SORT4_LAST_STEP) begin
            state    <= IDLE;
            step     <= 3'd0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            v[lo_idx] <= cmp_lo;
            v[hi_idx] <= cmp_hi;
            step      <= step + 3'd1;
            if (step == SORT4_LAST_STEP) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          // The result handoff edge never doubles as an accept edge.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          step      <= 3'd0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign ra = v[0];
  assign rb = v[1];
  assign rc = v[2];
  assign rd = v[3];

endmodule
